replacer_slot_ctrl: RTL and testbench

Sequences one PID-replacer packet slot: streams a 188-byte replacement packet (PACK_WORD_SIZE words) from the AXI register side into the replacer RAM, and reads it back through the replacer pump port. It checks the readback by XOR signature and index order. It then arms or disarms replacement, driving run_enable and the PID, and enforces a drain hold-off before the live RAM is overwritten. It sits between the AXI-lite register file and the replacer datapath, entirely in the S_AXI_ACLK domain.

---
 rtl/replacer_pkg.sv | 23 ++
 rtl/replacer_slot_ctrl_if.sv | 29 ++
 rtl/replacer_sig_accum.sv | 22 ++
 rtl/replacer_slot_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_replacer_slot_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/replacer_pkg.sv
// rtl/replacer_pkg.sv - shared constants and encodings for the replacer slot controller
package replacer_pkg;

    localparam int PACK_BYTE_SIZE = 188;
    localparam int PACK_WORD_SIZE = PACK_BYTE_SIZE / 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_ARMED  = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SIG     = 2'd1,
        ERR_INDEX   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

endpackage

// File: rtl/replacer_slot_ctrl_if.sv
// rtl/replacer_slot_ctrl_if.sv - host write stream and replacer RAM/pump port bundle
interface replacer_slot_ctrl_if #(
    parameter int DW = 32
) ();

    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          save_replace_data_enable;
    logic [DW-1:0] in_data;
    logic [DW-1:0] in_data_index;
    logic          pump_data_enable;
    logic [DW-1:0] out_data;
    logic [DW-1:0] out_data_index;
    logic          ready_for_read;

    // controller side
    modport master (
        input  wr_valid, wr_data, out_data, out_data_index, ready_for_read,
        output wr_ready, save_replace_data_enable, in_data, in_data_index, pump_data_enable
    );

    // host and replacer side
    modport slave (
        output wr_valid, wr_data, out_data, out_data_index, ready_for_read,
        input  wr_ready, save_replace_data_enable, in_data, in_data_index, pump_data_enable
    );

endinterface

// File: rtl/replacer_sig_accum.sv
// rtl/replacer_sig_accum.sv - clearable XOR signature accumulator
module replacer_sig_accum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    // clear wins over accumulate so a fresh packet never folds in a stale word
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/replacer_slot_ctrl.sv
// rtl/replacer_slot_ctrl.sv - load, verify and arm sequencer for one PID-replacer packet slot
module replacer_slot_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int PACK_WORD_SIZE     = replacer_pkg::PACK_WORD_SIZE,
    parameter int DRAIN_CYCLES       = 16,
    parameter int VERIFY_TIMEOUT     = 64
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic                          cmd_load,
    input  logic                          cmd_arm,
    input  logic                          cmd_disarm,
    input  logic                          cmd_abort,
    input  logic [12:0]                   pid_cfg,
    replacer_slot_ctrl_if.master          bus,
    output logic                          run_enable,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pid,
    output logic                          busy,
    output logic                          verify_ok,
    output logic                          error,
    output logic [1:0]                    error_code,
    output logic [2:0]                    state
);
    import replacer_pkg::*;

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int WCW = $clog2(PACK_WORD_SIZE + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam int VCW = $clog2(VERIFY_TIMEOUT + 1);

    state_t         state_q, state_d;
    err_t           code_q, raise;
    logic [WCW-1:0] word_cnt;
    logic [DCW-1:0] drain_cnt;
    logic [VCW-1:0] vcnt;
    logic           wr_ready_q, save_q, pump_q, run_q, busy_q, verify_ok_q, error_q;
    logic [DW-1:0]  in_data_q, in_idx_q, pid_q;
    logic [DW-1:0]  sig, rsig, rsig_final, exp_idx;
    logic           accept, rd_valid, start_load, do_arm, verify_pass;

    // an abort on the same cycle as a handshake discards that word
    assign accept     = bus.wr_valid && wr_ready_q && !cmd_abort;
    // pump rises one cycle after entry and the replacer adds one more
    assign rd_valid   = (state_q == ST_VERIFY) && (vcnt >= VCW'(2)) &&
                        (vcnt <= VCW'(PACK_WORD_SIZE + 1));
    assign exp_idx    = DW'(vcnt - VCW'(2));
    // include a word arriving together with ready_for_read
    assign rsig_final = rsig ^ (rd_valid ? bus.out_data : '0);

    replacer_sig_accum #(.W(DW)) u_sig (
        .clk (S_AXI_ACLK),
        .rst (S_AXI_ARESET),
        .clr (start_load),
        .en  (accept),
        .din (bus.wr_data),
        .acc (sig)
    );

    replacer_sig_accum #(.W(DW)) u_rsig (
        .clk (S_AXI_ACLK),
        .rst (S_AXI_ARESET),
        .clr (state_q != ST_VERIFY),
        .en  (rd_valid),
        .din (bus.out_data),
        .acc (rsig)
    );

    // next state and command decode, abort > disarm > load > arm
    always_comb begin
        state_d     = state_q;
        start_load  = 1'b0;
        do_arm      = 1'b0;
        verify_pass = 1'b0;
        raise       = ERR_NONE;
        if (cmd_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_load) begin
                        start_load = 1'b1;
                        state_d    = ST_LOAD;
                    end else if (cmd_arm && verify_ok_q) begin
                        do_arm  = 1'b1;
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (cmd_disarm) begin
                        state_d = ST_IDLE;
                    end else if (cmd_load) begin
                        start_load = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (accept && (word_cnt == WCW'(PACK_WORD_SIZE - 1))) state_d = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (rd_valid && (bus.out_data_index != exp_idx)) raise = ERR_INDEX;
                    if (bus.ready_for_read) begin
                        if ((rsig_final == sig) && !error_q && (raise == ERR_NONE)) begin
                            verify_pass = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            if (raise == ERR_NONE) raise = ERR_SIG;
                            state_d = ST_ERROR;
                        end
                    end else if (vcnt == VCW'(VERIFY_TIMEOUT - 1)) begin
                        if (raise == ERR_NONE) raise = ERR_TIMEOUT;
                        state_d = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (cmd_load) begin
                        start_load = 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            code_q      <= ERR_NONE;
            word_cnt    <= '0;
            drain_cnt   <= '0;
            vcnt        <= '0;
            wr_ready_q  <= 1'b0;
            save_q      <= 1'b0;
            pump_q      <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            verify_ok_q <= 1'b0;
            error_q     <= 1'b0;
            in_data_q   <= '0;
            in_idx_q    <= '0;
            pid_q       <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_ARMED);
            wr_ready_q <= (state_d == ST_LOAD);
            run_q      <= (state_d == ST_ARMED);
            pump_q     <= (state_q == ST_VERIFY) && (state_d == ST_VERIFY);
            save_q     <= accept;
            if (accept) begin
                in_data_q <= bus.wr_data;
                in_idx_q  <= DW'(word_cnt);
            end
            if (start_load)  word_cnt <= '0;
            else if (accept) word_cnt <= word_cnt + WCW'(1);
            drain_cnt <= (state_q == ST_DRAIN)  ? drain_cnt + DCW'(1) : '0;
            vcnt      <= (state_q == ST_VERIFY) ? vcnt + VCW'(1)      : '0;
            if (do_arm) pid_q <= DW'(pid_cfg);
            if (cmd_abort || start_load) verify_ok_q <= 1'b0;
            else if (verify_pass)        verify_ok_q <= 1'b1;
            if (start_load) begin
                error_q <= 1'b0;
                code_q  <= ERR_NONE;
            end else if (!error_q && (raise != ERR_NONE)) begin
                error_q <= 1'b1;
                code_q  <= raise;
            end
        end
    end

    assign bus.wr_ready                 = wr_ready_q;
    assign bus.save_replace_data_enable = save_q;
    assign bus.in_data                  = in_data_q;
    assign bus.in_data_index            = in_idx_q;
    assign bus.pump_data_enable         = pump_q;
    assign run_enable                   = run_q;
    assign pid                          = pid_q;
    assign busy                         = busy_q;
    assign verify_ok                    = verify_ok_q;
    assign error                        = error_q;
    assign error_code                   = code_q;
    assign state                        = state_q;

endmodule

// File: tb/tb_replacer_slot_ctrl.sv
// tb/tb_replacer_slot_ctrl.sv - randomized self-checking bench for replacer_slot_ctrl
module tb_replacer_slot_ctrl;

    localparam int NW    = 47;
    localparam int DRAIN = 16;
    localparam int VTO   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_load, cmd_arm, cmd_disarm, cmd_abort;
    logic [12:0] pid_cfg;
    logic        run_enable, busy, verify_ok, error;
    logic [31:0] pid;
    logic [1:0]  error_code;
    logic [2:0]  state;

    replacer_slot_ctrl_if #(.DW(32)) bus ();

    replacer_slot_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .PACK_WORD_SIZE     (NW),
        .DRAIN_CYCLES       (DRAIN),
        .VERIFY_TIMEOUT     (VTO)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .cmd_load     (cmd_load),
        .cmd_arm      (cmd_arm),
        .cmd_disarm   (cmd_disarm),
        .cmd_abort    (cmd_abort),
        .pid_cfg      (pid_cfg),
        .bus          (bus),
        .run_enable   (run_enable),
        .pid          (pid),
        .busy         (busy),
        .verify_ok    (verify_ok),
        .error        (error),
        .error_code   (error_code),
        .state        (state)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rd_ptr = 0;
    int          corrupt_idx = -1;
    logic        no_ready = 1'b0;
    logic        run_seen = 1'b0;
    logic [31:0] pkt [NW];
    logic [31:0] mem [64];
    logic [31:0] log_idx [$];
    logic [31:0] log_dat [$];
    int          log_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // replacer model: RAM writes, and a pump that streams stored words one cycle after enable
    always @(posedge clk) begin
        if (bus.save_replace_data_enable) mem[bus.in_data_index[5:0]] <= bus.in_data;
        if (rst || !bus.pump_data_enable) begin
            rd_ptr             <= 0;
            bus.ready_for_read <= 1'b0;
        end else if (rd_ptr < NW) begin
            bus.out_data       <= mem[rd_ptr] ^ ((rd_ptr == corrupt_idx) ? 32'd1 : 32'd0);
            bus.out_data_index <= rd_ptr;
            rd_ptr             <= rd_ptr + 1;
        end else if (!no_ready) begin
            bus.ready_for_read <= 1'b1;
        end
    end

    // strobe and run_enable observers
    always @(negedge clk) begin
        if (bus.save_replace_data_enable) begin
            log_idx.push_back(bus.in_data_index);
            log_dat.push_back(bus.in_data);
            log_cyc.push_back(cyc);
        end
        if (run_enable === 1'b1) run_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ld, input logic ar, input logic ds, input logic ab);
        cmd_load = ld; cmd_arm = ar; cmd_disarm = ds; cmd_abort = ab;
        step();
        cmd_load = 1'b0; cmd_arm = 1'b0; cmd_disarm = 1'b0; cmd_abort = 1'b0;
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NW; k++) pkt[k] = $urandom;
    endtask

    // offers words 0..stop_at-1, idling gap_len cycles before word gap_at
    task automatic feed(input int gap_at, input int gap_len, input int stop_at);
        int   i = 0;
        int   g = 0;
        int   guard = 0;
        logic rdy;
        while (i < stop_at && guard < 400) begin
            guard++;
            if (i == gap_at && g < gap_len) begin
                bus.wr_valid = 1'b0;
                g++;
                step();
            end else begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = pkt[i];
                rdy = bus.wr_ready;
                step();
                if (rdy) i++;
            end
        end
        bus.wr_valid = 1'b0;
        chk("feed_words", i, stop_at);
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n = 0;
        while (state !== target && n < budget) begin
            step();
            n++;
        end
        chk(tag, state, target);
    endtask

    task automatic check_log(input int n, input string tag);
        chk({tag, "_nstrobe"}, log_idx.size(), n);
        for (int k = 0; k < n && k < log_idx.size(); k++) begin
            chk($sformatf("%s_idx%0d", tag, k), log_idx[k], k);
            chk($sformatf("%s_dat%0d", tag, k), log_dat[k], pkt[k]);
        end
    endtask

    // verification outcome from the signatures of what was written and what is read back
    function automatic logic model_ok();
        logic [31:0] s = '0;
        logic [31:0] r = '0;
        for (int k = 0; k < NW; k++) begin
            s ^= pkt[k];
            r ^= pkt[k] ^ ((k == corrupt_idx) ? 32'd1 : 32'd0);
        end
        return s == r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   t_load;
        int   t0;
        int   n;
        int   gap_at;
        logic exp_ok;
        logic [12:0] rpid;

        rst = 1'b1;
        cmd_load = 1'b0; cmd_arm = 1'b0; cmd_disarm = 1'b0; cmd_abort = 1'b0;
        pid_cfg = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_run", run_enable, 0);
        chk("rst_pid", pid, 0);
        chk("rst_vok", verify_ok, 0);
        chk("rst_err", error, 0);
        chk("rst_code", error_code, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_save", bus.save_replace_data_enable, 0);
        chk("rst_pump", bus.pump_data_enable, 0);
        chk("rst_in_data", bus.in_data, 0);
        chk("rst_in_idx", bus.in_data_index, 0);
        rst = 1'b0;
        step();

        // counting packet, then arm
        for (int k = 0; k < NW; k++) pkt[k] = k;
        clear_log();
        pulse(1, 0, 0, 0);
        chk("a_state_load", state, 2);
        chk("a_busy", busy, 1);
        chk("a_wr_ready", bus.wr_ready, 1);
        feed(-1, 0, NW);
        wait_state(3'd0, 200, "a_done_state");
        check_log(NW, "a");
        chk("a_vok", verify_ok, 1);
        chk("a_err", error, 0);
        pid_cfg = 13'h0100;
        pulse(0, 1, 0, 0);
        chk("a_armed_state", state, 4);
        chk("a_run", run_enable, 1);
        chk("a_pid", pid, 32'h0000_0100);
        chk("a_busy_armed", busy, 0);

        // reload while armed: drain hold-off
        fill_rand();
        clear_log();
        t_load = cyc;
        pulse(1, 0, 0, 0);
        chk("b_run_fall", run_enable, 0);
        chk("b_state_drain", state, 1);
        chk("b_vok_clr", verify_ok, 0);
        feed(-1, 0, NW);
        wait_state(3'd0, 200, "b_done_state");
        check_log(NW, "b");
        if (log_cyc.size() > 0) chk("b_drain_gap", (log_cyc[0] - t_load) >= DRAIN + 1, 1);
        else chk("b_drain_gap", 0, 1);
        chk("b_vok", verify_ok, 1);

        // readback corruption on word 20
        fill_rand();
        corrupt_idx = 20;
        exp_ok = model_ok();
        clear_log();
        run_seen = 1'b0;
        pulse(1, 0, 0, 0);
        feed(-1, 0, NW);
        wait_state(exp_ok ? 3'd0 : 3'd5, 200, "c_state");
        chk("c_err", error, exp_ok ? 0 : 1);
        chk("c_code", error_code, exp_ok ? 0 : 1);
        chk("c_vok", verify_ok, exp_ok ? 1 : 0);
        chk("c_run_never", run_seen, 0);
        pulse(0, 1, 0, 0);
        chk("c_arm_ignored", state, 5);
        corrupt_idx = -1;

        // replacer never reports completion
        no_ready = 1'b1;
        fill_rand();
        clear_log();
        pulse(1, 0, 0, 0);
        chk("d_err_clr", error, 0);
        chk("d_code_clr", error_code, 0);
        chk("d_state_load", state, 2);
        feed(-1, 0, NW);
        chk("d_verify_entry", state, 3);
        t0 = cyc;
        n = 0;
        while (error_code !== 2'd3 && n < 200) begin
            step();
            n++;
        end
        chk("d_timeout_lat", cyc - t0, VTO);
        chk("d_code", error_code, 3);
        chk("d_pump_off", bus.pump_data_enable, 0);
        chk("d_state_err", state, 5);
        no_ready = 1'b0;

        // abort keeps error, then abort+load mid-packet
        pulse(0, 0, 0, 1);
        chk("e_abort_state", state, 0);
        chk("e_err_kept", error, 1);
        fill_rand();
        clear_log();
        pulse(1, 0, 0, 0);
        feed(-1, 0, 10);
        bus.wr_valid = 1'b1;
        bus.wr_data  = pkt[10];
        cmd_abort = 1'b1;
        cmd_load  = 1'b1;
        step();
        cmd_abort = 1'b0;
        cmd_load  = 1'b0;
        bus.wr_valid = 1'b0;
        chk("e_state", state, 0);
        chk("e_vok", verify_ok, 0);
        chk("e_wr_ready", bus.wr_ready, 0);
        repeat (20) step();
        chk("e_strobes", log_idx.size(), 10);
        chk("e_state_hold", state, 0);

        // five idle cycles before word 20
        fill_rand();
        clear_log();
        pulse(1, 0, 0, 0);
        feed(20, 5, NW);
        wait_state(3'd0, 200, "f_done_state");
        check_log(NW, "f");
        if (log_cyc.size() > 20) chk("f_gap", log_cyc[20] - log_cyc[19], 6);
        else chk("f_gap", 0, 6);
        chk("f_vok", verify_ok, 1);

        // randomized packets, corruption and gaps
        for (int it = 0; it < 4; it++) begin
            fill_rand();
            corrupt_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NW - 1)) : -1;
            gap_at = $urandom_range(1, NW - 1);
            exp_ok = model_ok();
            clear_log();
            pulse(1, 0, 0, 0);
            feed(gap_at, $urandom_range(0, 6), NW);
            wait_state(exp_ok ? 3'd0 : 3'd5, 200, $sformatf("g%0d_state", it));
            check_log(NW, $sformatf("g%0d", it));
            chk($sformatf("g%0d_vok", it), verify_ok, exp_ok);
            chk($sformatf("g%0d_code", it), error_code, exp_ok ? 0 : 1);
            if (exp_ok) begin
                rpid = 13'($urandom_range(0, 8191));
                pid_cfg = rpid;
                pulse(0, 1, 0, 0);
                chk($sformatf("g%0d_pid", it), pid, {19'd0, rpid});
                chk($sformatf("g%0d_run", it), run_enable, 1);
                pulse(0, 0, 1, 0);
                chk($sformatf("g%0d_disarm_run", it), run_enable, 0);
                chk($sformatf("g%0d_disarm_state", it), state, 0);
            end
        end
        corrupt_idx = -1;

        // reset in the middle of a load
        fill_rand();
        pulse(1, 0, 0, 0);
        feed(-1, 0, 5);
        rst = 1'b1;
        step();
        step();
        chk("h_state", state, 0);
        chk("h_wr_ready", bus.wr_ready, 0);
        chk("h_save", bus.save_replace_data_enable, 0);
        chk("h_vok", verify_ok, 0);
        chk("h_err", error, 0);
        chk("h_busy", busy, 0);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
